dmem_access_ctrl: RTL and testbench

// - Sequences data-memory accesses issued by the EX/MEM pipeline register (MemRead, MemWrite, lbSel, ALU address, store data).
// - Drives a variable-latency req/ack data-memory port, generates byte enables and load alignment, and stalls the pipeline until each access completes.
// - Sits between the EX/MEM register outputs and the MEM/WB register.

---
 rtl/dmem_ctrl_pkg.sv | 31 +++
 rtl/dmem_align.sv | 50 +++++
 rtl/dmem_access_ctrl.sv | 141 ++++++++++++++
 tb/tb_dmem_access_ctrl.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/dmem_ctrl_pkg.sv
// Shared encodings for the data-memory access controller: access sizes,
// FSM states, byte-enable base patterns and the alignment rule.
package dmem_ctrl_pkg;

    typedef enum logic [1:0] {
        LB_WORD  = 2'b00,
        LB_SBYTE = 2'b01,
        LB_SHALF = 2'b10,
        LB_UBYTE = 2'b11
    } lb_sel_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    localparam logic [3:0] BE_WORD = 4'b1111;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_BYTE = 4'b0001;

    // Bytes are always aligned; halves need an even address, words a multiple of 4.
    function automatic logic is_misaligned(input lb_sel_e sel, input logic [1:0] off);
        case (sel)
            LB_WORD:  return off != 2'b00;
            LB_SHALF: return off[0];
            default:  return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/dmem_align.sv
// Combinational lane logic: store-side byte enables and lane replication,
// load-side lane extraction with sign/zero extension.
module dmem_align
    import dmem_ctrl_pkg::*;
(
    input  lb_sel_e     st_sel,
    input  logic [1:0]  st_off,
    input  logic [31:0] wdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_lane,
    output logic        misaligned,
    input  lb_sel_e     ld_sel,
    input  logic [1:0]  ld_off,
    input  logic [31:0] rdata,
    output logic [31:0] load_data
);

    logic [31:0] lane;

    always_comb begin
        be         = BE_WORD;
        wdata_lane = wdata;
        case (st_sel)
            LB_SBYTE, LB_UBYTE: begin
                be         = BE_BYTE << st_off;
                wdata_lane = {4{wdata[7:0]}};
            end
            LB_SHALF: begin
                be         = BE_HALF << st_off;
                wdata_lane = {2{wdata[15:0]}};
            end
            default: ;
        endcase
    end

    assign misaligned = is_misaligned(st_sel, st_off);

    assign lane = rdata >> {ld_off, 3'b000};

    always_comb begin
        load_data = rdata;
        case (ld_sel)
            LB_SBYTE: load_data = {{24{lane[7]}}, lane[7:0]};
            LB_SHALF: load_data = {{16{lane[15]}}, lane[15:0]};
            LB_UBYTE: load_data = {24'h0, lane[7:0]};
            default:  load_data = rdata;
        endcase
    end

endmodule

// File: rtl/dmem_access_ctrl.sv
// Data-memory access sequencer between EX/MEM and MEM/WB: issues one req/ack
// transaction per load/store, stalls the pipeline until it completes or times out.
//
// state | meaning
// IDLE  | waiting for a load/store; aligned access launches, misaligned is dropped
// BUSY  | request outstanding, counting cycles toward timeout
// DONE  | result (or timeout) presented for one cycle, pipeline released
module dmem_access_ctrl
    import dmem_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read_i,
    input  logic        mem_write_i,
    input  logic [1:0]  lb_sel_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [31:0] dmem_addr_o,
    output logic [3:0]  dmem_be_o,
    output logic [31:0] dmem_wdata_o,
    input  logic        dmem_ack_i,
    input  logic [31:0] dmem_rdata_i,
    output logic [31:0] load_data_o,
    output logic        load_valid_o,
    output logic        stall_o,
    output logic        misalign_o,
    output logic        timeout_o
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_e           state, next_state;
    logic [CNT_W-1:0] cnt;
    lb_sel_e          ld_sel_q;
    logic [1:0]       ld_off_q;
    logic             is_read_q;

    logic             launch, drop, expired;
    logic [3:0]       be_c;
    logic [31:0]      wdata_c, load_c;
    logic             misaligned_c;

    dmem_align u_align (
        .st_sel     (lb_sel_e'(lb_sel_i)),
        .st_off     (addr_i[1:0]),
        .wdata      (wdata_i),
        .be         (be_c),
        .wdata_lane (wdata_c),
        .misaligned (misaligned_c),
        .ld_sel     (ld_sel_q),
        .ld_off     (ld_off_q),
        .rdata      (dmem_rdata_i),
        .load_data  (load_c)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        stall_o    = 1'b0;
        launch     = 1'b0;
        drop       = 1'b0;
        expired    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (mem_read_i || mem_write_i) begin
                    if (misaligned_c) begin
                        drop = 1'b1;
                    end else begin
                        launch     = 1'b1;
                        stall_o    = 1'b1;
                        next_state = ST_BUSY;
                    end
                end
            end
            ST_BUSY: begin
                stall_o = 1'b1;
                // an ack on the last allowed cycle still completes normally
                expired = !dmem_ack_i && (cnt == CNT_LAST);
                if (dmem_ack_i || expired) next_state = ST_DONE;
            end
            ST_DONE: next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt          <= '0;
            dmem_req_o   <= 1'b0;
            dmem_we_o    <= 1'b0;
            dmem_addr_o  <= '0;
            dmem_be_o    <= '0;
            dmem_wdata_o <= '0;
            load_data_o  <= '0;
            load_valid_o <= 1'b0;
            misalign_o   <= 1'b0;
            timeout_o    <= 1'b0;
            ld_sel_q     <= LB_WORD;
            ld_off_q     <= 2'b00;
            is_read_q    <= 1'b0;
        end else begin
            misalign_o   <= drop;
            load_valid_o <= 1'b0;
            timeout_o    <= 1'b0;
            if (launch) begin
                cnt          <= '0;
                dmem_req_o   <= 1'b1;
                dmem_we_o    <= mem_write_i;
                dmem_addr_o  <= {addr_i[31:2], 2'b00};
                dmem_be_o    <= be_c;
                dmem_wdata_o <= wdata_c;
                ld_sel_q     <= lb_sel_e'(lb_sel_i);
                ld_off_q     <= addr_i[1:0];
                is_read_q    <= !mem_write_i;
            end
            if (state == ST_BUSY) begin
                cnt <= cnt + CNT_W'(1);
                if (dmem_ack_i) begin
                    dmem_req_o   <= 1'b0;
                    load_valid_o <= is_read_q;
                    if (is_read_q) load_data_o <= load_c;
                end else if (expired) begin
                    dmem_req_o   <= 1'b0;
                    load_valid_o <= is_read_q;
                    load_data_o  <= '0;
                    timeout_o    <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl with a short timeout; the bench plays
// the memory, acking on a chosen BUSY cycle, and checks hand-computed results.
module tb_dmem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read_i, mem_write_i;
    logic [1:0]  lb_sel_i;
    logic [31:0] addr_i, wdata_i;
    logic        dmem_req_o, dmem_we_o;
    logic [31:0] dmem_addr_o;
    logic [3:0]  dmem_be_o;
    logic [31:0] dmem_wdata_o;
    logic        dmem_ack_i;
    logic [31:0] dmem_rdata_i;
    logic [31:0] load_data_o;
    logic        load_valid_o, stall_o, misalign_o, timeout_o;

    int n_cmp = 0;
    int n_err = 0;

    int          n_stall, n_req;
    logic        saw_valid, saw_tmo, saw_mis, hung;
    logic [31:0] cap_ld, cap_addr, cap_wdata;
    logic [3:0]  cap_be;
    logic        cap_we;

    dmem_access_ctrl #(.TIMEOUT_CYCLES(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .mem_read_i   (mem_read_i),
        .mem_write_i  (mem_write_i),
        .lb_sel_i     (lb_sel_i),
        .addr_i       (addr_i),
        .wdata_i      (wdata_i),
        .dmem_req_o   (dmem_req_o),
        .dmem_we_o    (dmem_we_o),
        .dmem_addr_o  (dmem_addr_o),
        .dmem_be_o    (dmem_be_o),
        .dmem_wdata_o (dmem_wdata_o),
        .dmem_ack_i   (dmem_ack_i),
        .dmem_rdata_i (dmem_rdata_i),
        .load_data_o  (load_data_o),
        .load_valid_o (load_valid_o),
        .stall_o      (stall_o),
        .misalign_o   (misalign_o),
        .timeout_o    (timeout_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One pipeline access: inputs held while stalled, ack on BUSY cycle ack_at (0 = never).
    task automatic do_access(input logic rd, input logic wr, input logic [1:0] sel,
                             input logic [31:0] a, input logic [31:0] wd,
                             input logic [31:0] rdv, input int ack_at);
        int   busy_n   = 0;
        logic stall_now;
        logic finished = 1'b0;
        mem_read_i = rd; mem_write_i = wr; lb_sel_i = sel; addr_i = a; wdata_i = wd;
        n_stall = 0; n_req = 0; saw_valid = 1'b0; saw_tmo = 1'b0; saw_mis = 1'b0;
        hung = 1'b1; cap_ld = 32'hX; cap_addr = '0; cap_wdata = '0; cap_be = '0; cap_we = 1'b0;
        for (int c = 0; c < 20 && !finished; c++) begin
            #1;
            stall_now = stall_o;
            if (stall_now) n_stall++;
            if (load_valid_o) saw_valid = 1'b1;
            if (timeout_o) saw_tmo = 1'b1;
            if (misalign_o) saw_mis = 1'b1;
            if (dmem_req_o) begin
                busy_n++;
                n_req++;
                cap_be = dmem_be_o; cap_we = dmem_we_o;
                cap_addr = dmem_addr_o; cap_wdata = dmem_wdata_o;
                dmem_ack_i   = (busy_n == ack_at);
                dmem_rdata_i = rdv;
            end
            if (!stall_now && c > 0) begin
                finished = 1'b1;
                hung     = 1'b0;
                cap_ld   = load_data_o;
            end
            @(posedge clk); #1;
            dmem_ack_i   = 1'b0;
            dmem_rdata_i = '0;
            if (!stall_now) begin
                mem_read_i  = 1'b0;
                mem_write_i = 1'b0;
            end
        end
        chk("no_hang", hung, 0);
    endtask

    initial begin
        rst = 1'b1; mem_read_i = 0; mem_write_i = 0; lb_sel_i = 0; addr_i = 0; wdata_i = 0;
        dmem_ack_i = 0; dmem_rdata_i = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("rst_req", dmem_req_o, 0);
        chk("rst_we", dmem_we_o, 0);
        chk("rst_addr", dmem_addr_o, 0);
        chk("rst_be", dmem_be_o, 0);
        chk("rst_wdata", dmem_wdata_o, 0);
        chk("rst_ld", load_data_o, 0);
        chk("rst_valid", load_valid_o, 0);
        chk("rst_mis", misalign_o, 0);
        chk("rst_tmo", timeout_o, 0);
        chk("rst_stall", stall_o, 0);
        @(posedge clk); #1;

        // LW 0x100, ack in first BUSY cycle
        do_access(1, 0, 2'b00, 32'h100, 32'h0, 32'hDEADBEEF, 1);
        chk("lw_stall", n_stall, 2);
        chk("lw_req", n_req, 1);
        chk("lw_be", cap_be, 4'b1111);
        chk("lw_addr", cap_addr, 32'h100);
        chk("lw_we", cap_we, 0);
        chk("lw_valid", saw_valid, 1);
        chk("lw_data", cap_ld, 32'hDEADBEEF);
        chk("lw_tmo", saw_tmo, 0);

        // SB 0x103, ack on the 4th BUSY cycle = the timeout cycle, so ack wins
        do_access(0, 1, 2'b01, 32'h103, 32'h000000A5, 32'h0, 4);
        chk("sb_be", cap_be, 4'b1000);
        chk("sb_wdata", cap_wdata, 32'hA5A5A5A5);
        chk("sb_we", cap_we, 1);
        chk("sb_addr", cap_addr, 32'h100);
        chk("sb_stall", n_stall, 5);
        chk("sb_req", n_req, 4);
        chk("sb_valid", saw_valid, 0);
        chk("sb_tmo", saw_tmo, 0);

        // LB / LBU 0x102
        do_access(1, 0, 2'b01, 32'h102, 32'h0, 32'h00800000, 2);
        chk("lb_data", cap_ld, 32'hFFFFFF80);
        chk("lb_be", cap_be, 4'b0100);
        chk("lb_stall", n_stall, 3);
        chk("lb_valid", saw_valid, 1);
        do_access(1, 0, 2'b11, 32'h102, 32'h0, 32'h00800000, 1);
        chk("lbu_data", cap_ld, 32'h00000080);

        // LH 0x106 sign-extends upper half
        do_access(1, 0, 2'b10, 32'h106, 32'h0, 32'h80011234, 1);
        chk("lh_data", cap_ld, 32'hFFFF8001);
        chk("lh_be", cap_be, 4'b1100);
        chk("lh_addr", cap_addr, 32'h104);

        // SH 0x102 replicates the low half
        do_access(0, 1, 2'b10, 32'h102, 32'h1234ABCD, 32'h0, 1);
        chk("sh_be", cap_be, 4'b1100);
        chk("sh_wdata", cap_wdata, 32'hABCDABCD);

        // Read and write together: write wins
        do_access(1, 1, 2'b00, 32'h10, 32'h11223344, 32'h55555555, 1);
        chk("rw_we", cap_we, 1);
        chk("rw_wdata", cap_wdata, 32'h11223344);
        chk("rw_valid", saw_valid, 0);

        // Misaligned word and half
        do_access(1, 0, 2'b00, 32'h102, 32'h0, 32'h0, 1);
        chk("mw_mis", saw_mis, 1);
        chk("mw_req", n_req, 0);
        chk("mw_stall", n_stall, 0);
        do_access(0, 1, 2'b10, 32'h101, 32'hFFFF, 32'h0, 1);
        chk("mh_mis", saw_mis, 1);
        chk("mh_req", n_req, 0);

        // Timeout: no ack
        do_access(1, 0, 2'b00, 32'h200, 32'h0, 32'h0, 0);
        chk("to_req", n_req, 4);
        chk("to_tmo", saw_tmo, 1);
        chk("to_data", cap_ld, 32'h0);
        chk("to_stall", n_stall, 5);
        #1;
        chk("to_idle_req", dmem_req_o, 0);
        chk("to_idle_stall", stall_o, 0);
        @(posedge clk); #1;

        // Reset in the 2nd BUSY cycle
        mem_read_i = 1; lb_sel_i = 2'b00; addr_i = 32'h300;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("mr_pre_req", dmem_req_o, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; mem_read_i = 0;
        #1;
        chk("mr_req", dmem_req_o, 0);
        chk("mr_stall", stall_o, 0);
        chk("mr_valid", load_valid_o, 0);
        chk("mr_tmo", timeout_o, 0);
        dmem_ack_i = 1; dmem_rdata_i = 32'hCAFEF00D;
        @(posedge clk); #1;
        dmem_ack_i = 0; dmem_rdata_i = 0;
        #1;
        chk("late_valid", load_valid_o, 0);
        chk("late_req", dmem_req_o, 0);
        chk("late_ld", load_data_o, 0);
        @(posedge clk); #1;
        do_access(1, 0, 2'b00, 32'h300, 32'h0, 32'h12345678, 1);
        chk("post_valid", saw_valid, 1);
        chk("post_data", cap_ld, 32'h12345678);
        chk("post_stall", n_stall, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
